systolic_feeder: RTL

- Input staging block directly upstream of the 4x4 systolic array.
- Accepts one 4x4 A block and one 4x4 B block, element by element, into a local register bank.
- On start, drives the array's four west and four north lanes with the diagonally skewed operand streams, zero-padded.
- Clears the array accumulators beforehand and waits for the array's done before accepting the next block.
- Operands are Q8.8 fixed point (0x0100 = 1.0); the block never interprets them.

---
 rtl/systolic_feeder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
// Operand staging for the 4x4 systolic array: holds one A and one B block and
// streams them diagonally skewed and zero-padded onto the west/north lanes.
module systolic_feeder #(
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [1:0]    wr_row,
  input  logic [1:0]    wr_col,
  input  logic [DW-1:0] wr_data,
  output logic          wr_drop,
  input  logic          start,
  output logic          busy,
  output logic          acc_clr,
  output logic [DW-1:0] out_west0,
  output logic [DW-1:0] out_west1,
  output logic [DW-1:0] out_west2,
  output logic [DW-1:0] out_west3,
  output logic [DW-1:0] out_north0,
  output logic [DW-1:0] out_north1,
  output logic [DW-1:0] out_north2,
  output logic [DW-1:0] out_north3,
  output logic          out_valid,
  input  logic          array_done,
  output logic          timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLR    = 2'd1,
    S_STREAM = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  localparam logic [7:0] LP_TLAST = 8'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic          w_timeout_hit;
  logic [2:0]    r_t;
  logic [7:0]    r_wcnt;
  logic [DW-1:0] r_a [4][4];
  logic [DW-1:0] r_b [4][4];
  logic [DW-1:0] w_west  [4];
  logic [DW-1:0] w_north [4];
  logic [DW-1:0] r_west  [4];
  logic [DW-1:0] r_north [4];
  logic          r_busy;
  logic          r_acc_clr;
  logic          r_valid;
  logic          r_wr_drop;
  logic          r_timeout;

  // Next-state decode; done takes priority over the timeout expiry.
  always_comb begin
    w_next        = r_state;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_CLR;
        else       w_next = S_IDLE;
      end
      S_CLR: w_next = S_STREAM;
      S_STREAM: begin
        if (r_t == 3'd6) w_next = S_WAIT;
        else             w_next = S_STREAM;
      end
      S_WAIT: begin
        if (array_done) begin
          w_next = S_IDLE;
        end else if (r_wcnt == LP_TLAST) begin
          w_next        = S_IDLE;
          w_timeout_hit = 1'b1;
        end else begin
          w_next = S_WAIT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Lane i/j carries element t-i of its row/column inside the 4-cycle window.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_west[i]  = '0;
      w_north[i] = '0;
      if (r_state == S_STREAM && r_t >= 3'(i) && r_t <= 3'(i + 3)) begin
        w_west[i]  = r_a[i][2'(r_t - 3'(i))];
        w_north[i] = r_b[2'(r_t - 3'(i))][i];
      end else begin
        w_west[i]  = '0;
        w_north[i] = '0;
      end
    end
  end

  // Control state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_t       <= 3'd0;
      r_wcnt    <= 8'd0;
      r_busy    <= 1'b0;
      r_acc_clr <= 1'b0;
      r_valid   <= 1'b0;
      r_wr_drop <= 1'b0;
      r_timeout <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_west[i]  <= '0;
        r_north[i] <= '0;
      end
    end else begin
      r_state   <= w_next;
      r_busy    <= (w_next != S_IDLE);
      r_acc_clr <= (r_state == S_IDLE) && start;
      r_valid   <= (r_state == S_STREAM);
      r_wr_drop <= wr_en && (r_state != S_IDLE);
      r_timeout <= w_timeout_hit;
      if (r_state == S_STREAM) r_t <= r_t + 3'd1;
      else                     r_t <= 3'd0;
      if (r_state == S_WAIT) r_wcnt <= r_wcnt + 8'd1;
      else                   r_wcnt <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        r_west[i]  <= w_west[i];
        r_north[i] <= w_north[i];
      end
    end
  end

  // Operand bank; only writable while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          r_a[r][c] <= '0;
          r_b[r][c] <= '0;
        end
      end
    end else if (wr_en && r_state == S_IDLE) begin
      if (wr_sel) r_b[wr_row][wr_col] <= wr_data;
      else        r_a[wr_row][wr_col] <= wr_data;
    end
  end

  assign busy       = r_busy;
  assign acc_clr    = r_acc_clr;
  assign out_valid  = r_valid;
  assign wr_drop    = r_wr_drop;
  assign timeout    = r_timeout;
  assign out_west0  = r_west[0];
  assign out_west1  = r_west[1];
  assign out_west2  = r_west[2];
  assign out_west3  = r_west[3];
  assign out_north0 = r_north[0];
  assign out_north1 = r_north[1];
  assign out_north2 = r_north[2];
  assign out_north3 = r_north[3];

endmodule
